coin_encoder: RTL



---
 rtl/vend_pkg.sv | 15 +
 rtl/coin_debounce.sv | 51 +++++
 rtl/coin_encoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the coin acceptor front end and the vending FSM.
//   COIN5 / COIN10 : value carried on the j wire while i is high
//   emit_state_t   : states of the coin code emitter in coin_encoder
package vend_pkg;

    localparam logic COIN5  = 1'b0;
    localparam logic COIN10 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } emit_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot sensor channel: 2-flop synchronizer, debounce counter and
// rising-edge detect of the debounced level.
// Ports:
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   raw   in  asynchronous sensor level
//   evt   out one-cycle pulse when the debounced level rises (registered)
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic evt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            evt     <= 1'b0;
        end else begin
            // synchronizer stages
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            evt     <= 1'b0;
            // Any sample matching the current level restarts the run, so only
            // an unbroken run of differing samples can flip the level.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
                evt   <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_encoder.sv
// Coin acceptor front end: debounces the 5-unit and 10-unit slot sensors,
// queues detected coins and replays each one as a single-cycle (i, j) code
// with forced idle spacing for the downstream vending FSM.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   coin5_raw, coin10_raw raw asynchronous slot sensors
//   accept_en             1 = queue new coins, 0 = discard new coins
//   i, j                  coin strobe and coin value (j is 0 unless i is 1)
//   busy                  queue non-empty or emitter not idle
//   overflow              sticky, set when a coin was dropped on a full queue
module coin_encoder
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic coin5_raw,
    input  logic coin10_raw,
    input  logic accept_en,
    output logic i,
    output logic j,
    output logic busy,
    output logic overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

    logic evt5;
    logic evt10;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (coin5_raw),
        .evt   (evt5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (coin10_raw),
        .evt   (evt10)
    );

    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         wr_ptr_b;
    logic [AW:0]           count;
    logic [AW:0]           count_nx;
    logic [AW:0]           free_slots;
    logic [1:0]            n_push;
    logic                  first_coin;
    logic                  drop;
    logic                  acc5;
    logic                  acc10;
    logic                  can_pop;
    logic                  pop;
    emit_state_t           state;
    emit_state_t           state_nx;
    logic [GW-1:0]         gap_cnt;

    always_comb begin
        acc5  = evt5 & accept_en;
        acc10 = evt10 & accept_en;

        // The emitter can take a new coin from IDLE, or straight out of the
        // last spacing cycle so back-to-back coins run at 1+GAP_CYCLES.
        case (state)
            IDLE:    can_pop = 1'b1;
            EMIT:    can_pop = (GAP_CYCLES == 0);
            GAP:     can_pop = (gap_cnt == GAP_LAST);
            default: can_pop = 1'b0;
        endcase
        pop = can_pop && (count != '0);

        // A pop on this edge frees a slot for a push on the same edge.
        free_slots = DEPTH - count + {{AW{1'b0}}, pop};
        n_push     = 2'd0;
        drop       = 1'b0;
        if (acc5 && acc10) begin
            if (free_slots > (AW+1)'(1)) begin
                n_push = 2'd2;
            end else if (free_slots == (AW+1)'(1)) begin
                n_push = 2'd1;
                drop   = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (acc5 || acc10) begin
            if (free_slots != '0) begin
                n_push = 2'd1;
            end else begin
                drop = 1'b1;
            end
        end
        // When both arrive the 5-unit coin goes first; the second slot is
        // then always the 10-unit coin.
        first_coin = acc5 ? COIN5 : COIN10;
        wr_ptr_b   = wr_ptr + AW'(1);
        count_nx   = count + (AW+1)'(n_push) - (AW+1)'(pop);

        case (state)
            IDLE:    state_nx = pop ? EMIT : IDLE;
            EMIT:    state_nx = (GAP_CYCLES > 0) ? GAP : (pop ? EMIT : IDLE);
            GAP:     state_nx = (gap_cnt == GAP_LAST) ? (pop ? EMIT : IDLE) : GAP;
            default: state_nx = IDLE;
        endcase
    end

    // queue storage carries no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem[wr_ptr] <= first_coin;
        end
        if (n_push == 2'd2) begin
            mem[wr_ptr_b] <= COIN10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            i        <= 1'b0;
            j        <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nx;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            count   <= count_nx;
            wr_ptr  <= wr_ptr + AW'(n_push);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            i    <= pop;
            j    <= pop ? mem[rd_ptr] : 1'b0;
            busy <= (count_nx != '0) || (state_nx != IDLE);
        end
    end

endmodule
